// File: rtl/mu0_loader.sv
// -----------------------------------------------------------------------------
// mu0_loader
//
// Program loader for the MU0 core. It takes a byte stream over a valid/ready
// handshake, assembles big-endian 16-bit words and writes them into the core's
// word memory starting at address 0. The core is held in reset until the whole
// image has been written and its 8-bit checksum has matched.
//
// Stream: LEN_HI, LEN_LO (word count N), N x {HI, LO}, CHK.
// CHK is the mod-256 sum of every byte before it, length bytes included.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins or restarts a load
//   in_valid   in_data carries a valid byte
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (registered)
//   mem_we     one-cycle memory write strobe
//   mem_addr   word address of the write
//   mem_wdata  word written
//   cpu_reset  active-high hold for the MU0 core
//   done       image loaded and verified
//   error      load failed (length too large or checksum mismatch)
// -----------------------------------------------------------------------------
module mu0_loader #(
    parameter int MAXWIDTH = 16,
    parameter int MAXDEPTH = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [MAXDEPTH-1:0] mem_addr,
    output logic [MAXWIDTH-1:0] mem_wdata,
    output logic                cpu_reset,
    output logic                done,
    output logic                error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_CHK     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    // Largest legal word count is 2^MAXDEPTH, which needs one bit more than
    // the address, so the comparison is done in 32 bits.
    localparam logic [31:0] MAX_WORDS = 32'd1 << MAXDEPTH;

    logic [2:0]          state_q,     state_d;
    logic [15:0]         len_q,       len_d;
    logic [MAXDEPTH-1:0] idx_q,       idx_d;
    logic [7:0]          sum_q,       sum_d;
    logic [7:0]          hi_q,        hi_d;
    logic                in_ready_q,  in_ready_d;
    logic                mem_we_q,    mem_we_d;
    logic [MAXDEPTH-1:0] mem_addr_q,  mem_addr_d;
    logic [MAXWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic        accept;
    logic [15:0] n_full;
    logic        last_word;

    assign accept    = in_valid & in_ready_q;
    assign n_full    = {len_q[15:8], in_data};
    // Index is not advanced on the final word, so for N = 2^MAXDEPTH it
    // stays at all ones instead of wrapping.
    assign last_word = ((32'(idx_q) + 32'd1) == 32'(len_q));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // start wins over any byte handshaken in the same cycle; that byte
        // is dropped. Memory contents already written are left alone.
        if (start) begin
            state_d = S_LEN_HI;
            len_d   = '0;
            idx_d   = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                S_LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = in_data;
                        sum_d       = sum_q + in_data;
                        state_d     = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_d = n_full;
                        sum_d = sum_q + in_data;
                        if (32'(n_full) > MAX_WORDS) begin
                            state_d = S_ERROR;
                        end else if (n_full == 16'd0) begin
                            state_d = S_CHK;
                        end else begin
                            state_d = S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        hi_d    = in_data;
                        sum_d   = sum_q + in_data;
                        state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = MAXWIDTH'({hi_q, in_data});
                        sum_d       = sum_q + in_data;
                        if (last_word) begin
                            state_d = S_CHK;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_DATA_HI;
                        end
                    end
                end
                S_CHK: begin
                    // The checksum byte itself is compared, never accumulated.
                    if (accept) begin
                        state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
                    end
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Status outputs are registered decodes of the next state so they
        // change together with the state register.
        in_ready_d  = (state_d == S_LEN_HI)  || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                      (state_d == S_CHK);
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/mu0_loader.md
Name: mu0_loader

Overview:
- Upstream program loader for the MU0 core.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit words from it.
- Writes those words sequentially into the core's word memory from address 0.
- Holds the core in reset until a complete image with a correct checksum has been written. Replaces the static memory-file preload for hardware bring-up.

Parameters:
- MAXWIDTH, 16, memory word width in bits; must be 16 (two bytes per word).
- MAXDEPTH, 12, memory address width; the image holds at most 2^MAXDEPTH words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  MAXDEPTH  write word address.
- mem_wdata  output  MAXWIDTH  write data.
- cpu_reset  output  1  active-high hold for the MU0 core.
- done  output  1  image loaded and verified.
- error  output  1  load failed.

Behaviour:
- Reset (reset=0, asynchronous) drives the following, in state IDLE:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - Word count, word index and checksum cleared.
- Stream format, in order:
  - LEN_HI, LEN_LO: word count N, 16-bit, big-endian.
  - N pairs of {HI, LO} data bytes.
  - One CHK byte equal to the 8-bit sum mod 256 of every preceding byte, length bytes included.
- Byte transfer: a byte is accepted only on a cycle where in_valid=1 and in_ready=1. in_data is ignored otherwise.
- in_ready=1 exactly in states LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK. It is a registered function of the state.
- States and transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: byte accepted -> LEN_LO.
  - LEN_LO: byte accepted -> N complete, then:
    - N > 2^MAXDEPTH -> ERROR.
    - N = 0 -> CHK.
    - otherwise -> DATA_HI.
  - DATA_HI: byte accepted -> latch high byte -> DATA_LO.
  - DATA_LO: byte accepted -> next state is CHK if this was word N-1, else DATA_HI.
  - CHK: byte accepted -> DONE if the byte matches the running sum, else ERROR.
  - DONE: cpu_reset=0, done=1. start -> LEN_HI.
  - ERROR: cpu_reset=1, error=1. start -> LEN_HI.
- Memory write timing:
  - On the edge that accepts a DATA_LO byte, mem_we is registered to 1 for exactly one cycle.
  - In that cycle mem_wdata={hi,lo} and mem_addr=index.
  - index increments after the write; word k is written to address k.
- Latency:
  - Word visible on the memory port 1 cycle after its LO byte is accepted.
  - done asserted 1 cycle after the CHK byte is accepted.
- start semantics:
  - start in any state, including mid-load, clears index, checksum, done and error, asserts cpu_reset, and goes to LEN_HI.
  - Memory already written is not cleared.
  - start has priority over a byte accepted in the same cycle; that byte is discarded.
- The checksum accumulator is 8 bits and wraps silently. The CHK byte is not added to it.
- N = 2^MAXDEPTH is legal: the last address is all ones and index does not wrap before CHK.
- Asynchronous reset mid-load aborts the load: cpu_reset=1 immediately and state IDLE.
- cpu_reset is never deasserted except in DONE.

Test Plan:
- Reset, start, then stream 00 02 00 0A 70 00 7C with in_valid held high:
  - mem_we pulses twice: (addr 0, 0x000A), then (addr 1, 0x7000).
  - done=1 and cpu_reset=0 one cycle after 7C is accepted.
- Same stream with CHK=7D -> error=1, done=0, cpu_reset stays 1. A following start plus the correct stream -> done=1.
- Stream 00 00 00 (N=0) -> no mem_we pulses, done=1.
- Stream 10 01 (N=4097, MAXDEPTH=12) -> error=1 after LEN_LO, in_ready=0, no writes.
- Gapped in_valid toggling 1/0 during the first test's stream:
  - writes and done are identical to the first test; done is merely delayed.
  - No byte is accepted while in_valid=0.
- Mid-load cases:
  - start pulsed after 3 bytes, then the full first-test stream -> writes begin again at addr 0 and done=1.
  - reset=0 mid-load -> cpu_reset=1, in_ready=0 asynchronously.
